// File: rtl/gb_cpu_regfile_banked.sv
// Banked CPU register file: byte/pair access, prioritised write ports, pair
// inc/dec, flag nibble merge and a shadow bank with a context copy engine.
module gb_cpu_regfile_banked #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned NUM_WR   = 3,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned FLAG_IDX = 1,
    parameter logic [NUM_REGS*8-1:0] RESET_VALUES = '0,
    localparam int unsigned IDXW  = $clog2(NUM_REGS),
    localparam int unsigned PIDXW = $clog2(NUM_REGS/2)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR-1:0]       wr_pair,
    input  logic [NUM_WR*IDXW-1:0]  wr_idx,
    input  logic [NUM_WR*16-1:0]    wr_data,
    input  logic                    inc_en,
    input  logic                    inc_dec,
    input  logic [PIDXW-1:0]        inc_pidx,
    input  logic                    flag_wr_en,
    input  logic [3:0]              flag_mask,
    input  logic [3:0]              flag_data,
    input  logic [NUM_RD*PIDXW-1:0] rd_pidx,
    output logic [NUM_RD*16-1:0]    rd_data,
    input  logic                    ctx_save,
    input  logic                    ctx_restore,
    output logic                    ctx_busy,
    output logic                    ctx_done,
    output logic [NUM_REGS*8-1:0]   regs
);

    localparam int unsigned NUM_PAIRS = NUM_REGS / 2;

    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

    state_t           state_q, state_d;
    logic [PIDXW-1:0] ptr_q, ptr_d;

    logic [7:0] act_q [NUM_REGS];
    logic [7:0] act_d [NUM_REGS];
    logic [7:0] shd_q [NUM_REGS];
    logic [7:0] shd_d [NUM_REGS];

    logic [NUM_WR-1:0][NUM_REGS-1:0] port_hit;
    logic [NUM_REGS-1:0]             wr_claim;

    // Which write port addresses which byte; out-of-range indices match nothing.
    always_comb begin
        logic hit;
        hit      = 1'b0;
        port_hit = '0;
        wr_claim = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            for (int p = 0; p < int'(NUM_WR); p++) begin
                if (wr_pair[p])
                    hit = (wr_idx[p*IDXW+1 +: IDXW-1] == (IDXW-1)'(i >> 1));
                else
                    hit = (wr_idx[p*IDXW +: IDXW] == IDXW'(i));
                port_hit[p][i] = wr_en[p] && hit;
                if (port_hit[p][i])
                    wr_claim[i] = 1'b1;
            end
        end
    end

    // Next value of both banks: copy engine, then ports, inc unit, flag merge.
    always_comb begin
        logic        flag_upd;
        logic [15:0] sum;
        act_d    = act_q;
        shd_d    = shd_q;
        flag_upd = 1'b0;
        sum      = '0;
        if (state_q == SAVE) begin
            for (int j = 0; j < int'(NUM_PAIRS); j++) begin
                if (ptr_q == PIDXW'(j)) begin
                    shd_d[2*j]   = act_q[2*j];
                    shd_d[2*j+1] = act_q[2*j+1];
                end
            end
        end else if (state_q == RESTORE) begin
            for (int j = 0; j < int'(NUM_PAIRS); j++) begin
                if (ptr_q == PIDXW'(j)) begin
                    act_d[2*j]   = shd_q[2*j];
                    act_d[2*j+1] = shd_q[2*j+1];
                    if (j == int'(FLAG_IDX / 2))
                        flag_upd = 1'b1;
                end
            end
        end else begin
            // lowest priority first so higher-priority sources overwrite
            if (flag_wr_en) begin
                for (int k = 0; k < 4; k++) begin
                    if (flag_mask[k])
                        act_d[FLAG_IDX][4+k] = flag_data[k];
                end
                flag_upd = 1'b1;
            end
            for (int j = 0; j < int'(NUM_PAIRS); j++) begin
                if (inc_en && inc_pidx == PIDXW'(j) && !wr_claim[2*j] && !wr_claim[2*j+1]) begin
                    sum = {act_q[2*j], act_q[2*j+1]} + (inc_dec ? 16'hFFFF : 16'h0001);
                    act_d[2*j]   = sum[15:8];
                    act_d[2*j+1] = sum[7:0];
                    if (j == int'(FLAG_IDX / 2))
                        flag_upd = 1'b1;
                end
            end
            for (int p = int'(NUM_WR) - 1; p >= 0; p--) begin
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    if (port_hit[p][i]) begin
                        if (wr_pair[p] && (i % 2) == 0)
                            act_d[i] = wr_data[p*16+8 +: 8];
                        else
                            act_d[i] = wr_data[p*16 +: 8];
                        if (i == int'(FLAG_IDX))
                            flag_upd = 1'b1;
                    end
                end
            end
        end
        if (flag_upd)
            act_d[FLAG_IDX][3:0] = 4'h0;
    end

    // Register banks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                act_q[i] <= RESET_VALUES[8*i +: 8];
                shd_q[i] <= 8'h00;
            end
        end else begin
            act_q <= act_d;
            shd_q <= shd_d;
        end
    end

    // Context copy FSM next state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (ctx_save) begin
                    state_d = SAVE;
                    ptr_d   = '0;
                end else if (ctx_restore) begin
                    state_d = RESTORE;
                    ptr_d   = '0;
                end
            end
            SAVE, RESTORE: begin
                if (ptr_q == PIDXW'(NUM_PAIRS - 1))
                    state_d = DONE;
                else
                    ptr_d = ptr_q + PIDXW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Context FSM state and its status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            ctx_busy <= 1'b0;
            ctx_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ctx_busy <= (state_d == SAVE) || (state_d == RESTORE);
            ctx_done <= (state_d == DONE);
        end
    end

    // Combinational pair reads of the active bank.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < int'(NUM_RD); r++) begin
            for (int j = 0; j < int'(NUM_PAIRS); j++) begin
                if (rd_pidx[r*PIDXW +: PIDXW] == PIDXW'(j))
                    rd_data[r*16 +: 16] = {act_q[2*j], act_q[2*j+1]};
            end
        end
    end

    // Flat view of the active bank.
    always_comb begin
        regs = '0;
        for (int i = 0; i < int'(NUM_REGS); i++)
            regs[8*i +: 8] = act_q[i];
    end

endmodule

// File: tb/tb_gb_cpu_regfile_banked.sv
// Directed bench for gb_cpu_regfile_banked with default parameters.
module tb_gb_cpu_regfile_banked;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [2:0]   wr_en, wr_pair;
    logic [11:0]  wr_idx;
    logic [47:0]  wr_data;
    logic         inc_en, inc_dec;
    logic [2:0]   inc_pidx;
    logic         flag_wr_en;
    logic [3:0]   flag_mask, flag_data;
    logic [5:0]   rd_pidx;
    logic [31:0]  rd_data;
    logic         ctx_save, ctx_restore;
    logic         ctx_busy, ctx_done;
    logic [127:0] regs;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [127:0] pat, fill;

    gb_cpu_regfile_banked dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_pair(wr_pair), .wr_idx(wr_idx), .wr_data(wr_data),
        .inc_en(inc_en), .inc_dec(inc_dec), .inc_pidx(inc_pidx),
        .flag_wr_en(flag_wr_en), .flag_mask(flag_mask), .flag_data(flag_data),
        .rd_pidx(rd_pidx), .rd_data(rd_data),
        .ctx_save(ctx_save), .ctx_restore(ctx_restore),
        .ctx_busy(ctx_busy), .ctx_done(ctx_done), .regs(regs)
    );

    always #5 clk = ~clk;

    task automatic clr();
        wr_en = '0; wr_pair = '0; wr_idx = '0; wr_data = '0;
        inc_en = 1'b0; inc_dec = 1'b0; inc_pidx = '0;
        flag_wr_en = 1'b0; flag_mask = '0; flag_data = '0;
        ctx_save = 1'b0; ctx_restore = 1'b0;
    endtask

    task automatic wr(input int p, input logic pr, input logic [3:0] idx, input logic [15:0] d);
        wr_en[p] = 1'b1;
        wr_pair[p] = pr;
        wr_idx[p*4 +: 4] = idx;
        wr_data[p*16 +: 16] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] rg(input int i);
        return regs[8*i +: 8];
    endfunction

    task automatic load_image(input logic [127:0] img);
        for (int j = 0; j < 8; j++) begin
            wr(0, 1'b1, 4'(2*j), {img[16*j +: 8], img[16*j+8 +: 8]});
            tick();
        end
    endtask

    initial begin
        clr();
        rd_pidx = '0;
        for (int i = 0; i < 16; i++) begin
            pat[8*i +: 8]  = 8'hA0 + 8'(i);
            fill[8*i +: 8] = 8'h5A;
        end
        pat[15:8]  = 8'hA0;
        fill[15:8] = 8'h50;

        // reset state
        #12;
        chk("reset_regs", regs, '0);
        chk("reset_busy", 128'(ctx_busy), 128'(0));
        chk("reset_done", 128'(ctx_done), 128'(0));
        reset = 1'b1;
        repeat (3) tick();
        chk("idle_regs", regs, '0);
        chk("idle_busy", 128'(ctx_busy), 128'(0));

        // byte write on port 0 beats pair write on port 2 for reg3
        wr(0, 1'b0, 4'd3, 16'h00AA);
        wr(2, 1'b1, 4'd2, 16'h1234);
        tick();
        chk("prio_reg2", 128'(rg(2)), 128'(8'h12));
        chk("prio_reg3", 128'(rg(3)), 128'(8'hAA));
        rd_pidx = {3'd0, 3'd1};
        #1;
        chk("rd_pair1", 128'(rd_data[15:0]), 128'(16'h12AA));

        // inc/dec wrap on pair2
        wr(1, 1'b1, 4'd5, 16'hFFFF);
        tick();
        rd_pidx = {3'd3, 3'd2};
        #1;
        chk("pair2_load", 128'(rd_data[15:0]), 128'(16'hFFFF));
        inc_en = 1'b1; inc_dec = 1'b0; inc_pidx = 3'd2;
        tick();
        chk("inc_wrap", 128'(rd_data[15:0]), 128'(16'h0000));
        inc_en = 1'b1; inc_dec = 1'b1; inc_pidx = 3'd2;
        tick();
        chk("dec_wrap", 128'(rd_data[15:0]), 128'(16'hFFFF));
        inc_en = 1'b1; inc_dec = 1'b0; inc_pidx = 3'd2;
        wr(0, 1'b0, 4'd4, 16'h0055);
        tick();
        chk("inc_drop_r4", 128'(rg(4)), 128'(8'h55));
        chk("inc_drop_r5", 128'(rg(5)), 128'(8'hFF));

        // two byte writes to the same register; then pair vs byte split
        wr(0, 1'b0, 4'd6, 16'h0011);
        wr(1, 1'b0, 4'd6, 16'h0022);
        tick();
        chk("byte_prio_r6", 128'(rg(6)), 128'(8'h11));
        wr(1, 1'b1, 4'd6, 16'hBEEF);
        wr(0, 1'b0, 4'd7, 16'h0077);
        tick();
        chk("split_pair3", 128'(rd_data[31:16]), 128'(16'hBE77));

        // flag merge and low-nibble forcing
        flag_wr_en = 1'b1; flag_mask = 4'b1010; flag_data = 4'b1111;
        tick();
        chk("flag_merge1", 128'(rg(1)), 128'(8'hA0));
        flag_wr_en = 1'b1; flag_mask = 4'b0101; flag_data = 4'b0100;
        tick();
        chk("flag_merge2", 128'(rg(1)), 128'(8'hE0));
        wr(0, 1'b1, 4'd1, 16'h12FF);
        tick();
        chk("flag_pair_r0", 128'(rg(0)), 128'(8'h12));
        chk("flag_pair_r1", 128'(rg(1)), 128'(8'hF0));
        flag_wr_en = 1'b1; flag_mask = 4'b1111; flag_data = 4'b0000;
        wr(2, 1'b0, 4'd1, 16'h003C);
        tick();
        chk("flag_port_wins", 128'(rg(1)), 128'(8'h30));

        // context save with a dropped write during the copy
        load_image(pat);
        chk("pattern", regs, pat);
        ctx_save = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("save_busy%0d", k), 128'({ctx_busy, ctx_done}), 128'(2'b10));
            if (k == 2) wr(0, 1'b0, 4'd5, 16'h0000);
            tick();
        end
        chk("save_done", 128'({ctx_busy, ctx_done}), 128'(2'b01));
        chk("busy_wr_drop", 128'(rg(5)), 128'(8'hA5));
        tick();
        chk("save_done_end", 128'(ctx_done), 128'(0));

        // overwrite, then restore
        load_image(fill);
        chk("fill", regs, fill);
        ctx_restore = 1'b1;
        tick();
        repeat (8) tick();
        chk("restore_done", 128'({ctx_busy, ctx_done}), 128'(2'b01));
        chk("restored", regs, pat);
        tick();

        // reset in the 4th save cycle
        ctx_save = 1'b1;
        tick();
        repeat (3) tick();
        chk("mid_busy_pre", 128'(ctx_busy), 128'(1));
        reset = 1'b0;
        #1;
        chk("mid_busy_rst", 128'({ctx_busy, ctx_done}), 128'(2'b00));
        chk("mid_regs_rst", regs, '0);
        #2;
        reset = 1'b1;
        tick();
        chk("mid_no_done", 128'({ctx_busy, ctx_done}), 128'(2'b00));
        load_image(pat);
        ctx_restore = 1'b1;
        tick();
        repeat (8) tick();
        chk("shadow_zero_done", 128'(ctx_done), 128'(1));
        chk("shadow_zero", regs, '0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/gb_cpu_regfile_banked.md
Name: gb_cpu_regfile_banked

Overview:
- Parametrised successor to the CPU register file: an array of 8-bit registers addressable as bytes or as 16-bit hi:lo pairs.
- N prioritised write ports, a pair increment/decrement unit, masked flag-nibble merge and combinational pair read ports.
- A shadow bank with a multi-cycle context save/restore engine, used by interrupt entry/exit and debug.
- Sits between the CPU control/ALU/IDU datapath and the operand muxes.

Parameters:
- NUM_REGS, 16: number of 8-bit registers; even, ≥4. Pair p = {reg[2p] (hi), reg[2p+1] (lo)}.
- NUM_WR, 3: write ports; port 0 has highest priority.
- NUM_RD, 2: 16-bit pair read ports.
- FLAG_IDX, 1: byte index of the flag register.
- RESET_VALUES, {16{8'h00}}: packed NUM_REGS*8 reset image; reg[i] = RESET_VALUES[8i+:8].
- Derived: IDXW = clog2(NUM_REGS), PIDXW = clog2(NUM_REGS/2).

Ports:
- clk  in  1  machine clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  NUM_WR  per-port write enable.
- wr_pair  in  NUM_WR  1 = 16-bit pair write; 0 = byte write.
- wr_idx  in  NUM_WR*IDXW  byte index; for pair writes the LSB is ignored (pair = idx>>1).
- wr_data  in  NUM_WR*16  byte writes use [7:0]; pair writes use [15:8]→hi, [7:0]→lo.
- inc_en  in  1  increment/decrement request.
- inc_dec  in  1  1 = decrement, 0 = increment.
- inc_pidx  in  PIDXW  target pair.
- flag_wr_en  in  1  flag merge enable.
- flag_mask  in  4  selects which of Z,N,H,C are updated.
- flag_data  in  4  new {Z,N,H,C}.
- rd_pidx  in  NUM_RD*PIDXW  read pair select.
- rd_data  out  NUM_RD*16  combinational read of the active bank.
- ctx_save  in  1  start copy active→shadow.
- ctx_restore  in  1  start copy shadow→active.
- ctx_busy  out  1  high while a copy is in progress.
- ctx_done  out  1  one-cycle pulse when a copy finishes.
- regs  out  NUM_REGS*8  flat view of the active bank.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - Active bank = RESET_VALUES; shadow bank = all zero.
  - FSM = IDLE; ctx_busy = 0, ctx_done = 0.
- Per-byte next-value priority, highest first:
  - Context copy (FSM busy).
  - wr ports 0..NUM_WR-1.
  - inc unit.
  - Flag merge (FLAG_IDX byte only).
  - Hold.
- Write rules:
  - A pair write claims both bytes at that port's priority.
  - A lower-priority source may still write a byte the higher-priority source did not claim.
  - Out-of-range indices are ignored; no state changes.
- Inc unit:
  - Computes pair ± 1 on the pre-edge value, mod 2^16 (0xFFFF+1 = 0x0000; 0x0000-1 = 0xFFFF).
  - Written only if no wr port touches either byte of that pair; otherwise the whole inc is dropped (no split carry).
- Flag register:
  - Flag merge: reg[FLAG_IDX][7:4] bit k takes flag_data[k] where flag_mask[k] = 1.
  - Bits [3:0] of reg[FLAG_IDX] are forced to 0 on every update from any source, including pair writes and context restore.
- Reads: rd_data and regs are combinational from the active bank; no write-through bypass, so writes are visible the cycle after the edge.
- FSM states: IDLE, SAVE, RESTORE, DONE.
  - IDLE: ctx_save → SAVE (ptr = 0); else ctx_restore → RESTORE (ptr = 0). Simultaneous requests: save wins.
  - SAVE / RESTORE: copy pair ptr, one pair per cycle. After ptr = NUM_REGS/2-1 → DONE.
  - DONE: ctx_done = 1 for one cycle → IDLE.
  - Copy length: NUM_REGS/2 cycles.
  - ctx_busy = 1 in SAVE and RESTORE only.
- During ctx_busy, all wr/inc/flag requests are dropped, not queued; the issuer must hold off.
- ctx_save/ctx_restore asserted outside IDLE are ignored.
- Reset mid-copy: FSM → IDLE immediately; both banks take their reset values; no ctx_done pulse.

Test Plan:
- Reset with default params → regs all 0x00, ctx_busy = 0; release reset, no inputs for 3 cycles → no change.
- Port 0 byte write reg[3] = 0xAA and port 2 pair write pair1 = 0x1234 in the same cycle → reg[2] = 0x12, reg[3] = 0xAA.
- pair2 = 0xFFFF, inc_en, inc_dec = 0 → 0x0000. Repeat with inc_dec = 1 → 0xFFFF. inc on pair2 with a same-cycle port write of reg[4] = 0x55 → reg[4] = 0x55, reg[5] unchanged.
- reg[1] = 0x00; flag merge with mask 4'b1010, data 4'b1111 → 0xA0. Pair write pair0 = 0x12FF → reg[1] = 0xF0.
- Load a distinct pattern, ctx_save → ctx_busy high for exactly 8 cycles, then ctx_done pulse. Overwrite all registers, ctx_restore → pattern restored. A wr during busy leaves its register unchanged.
- Assert reset low on the 4th SAVE cycle → ctx_busy falls asynchronously, no ctx_done; after release, shadow = 0 and ctx_restore yields all 0x00.
